// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcode, control-word and funct7 constants shared by the decode stage.
package decode_pkg;
    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_ARITH_I = 5'b00100;
    localparam logic [4:0] OP_ARITH_R = 5'b01100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;
    localparam logic [4:0] OP_FENCE   = 5'b00011;

    localparam int MUXSEL_HI = 10;
    localparam int MUXSEL_LO = 9;
    localparam int JAL       = 8;
    localparam int BRANCH    = 7;
    localparam int MEMREAD   = 6;
    localparam int MEMTOREG  = 5;
    localparam int ALUOP_HI  = 4;
    localparam int ALUOP_LO  = 3;
    localparam int MEMWRITE  = 2;
    localparam int ALUSRC    = 1;
    localparam int REGWRITE  = 0;

    localparam logic [10:0] CTRL_LOAD    = 11'b00_0011_00_011;
    localparam logic [10:0] CTRL_STORE   = 11'b00_0001_00_110;
    localparam logic [10:0] CTRL_BRANCH  = 11'b00_0100_01_000;
    localparam logic [10:0] CTRL_JUMP    = 11'b01_1000_00_011;
    localparam logic [10:0] CTRL_ARITH_I = 11'b00_0000_10_011;
    localparam logic [10:0] CTRL_ARITH_R = 11'b00_0000_10_001;
    localparam logic [10:0] CTRL_AUIPC   = 11'b10_0000_00_011;
    localparam logic [10:0] CTRL_LUI     = 11'b11_0000_11_011;

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    typedef enum logic {RUN, DIV_WAIT} div_state_t;

    // DIV/DIVU/REM/REMU all have funct3[2] set; MUL variants do not
    function automatic logic is_div(input logic mext, input logic [2:0] funct3);
        return mext & funct3[2];
    endfunction
endpackage

// File: rtl/rv_decode.sv
// rv_decode: combinational RV32I(+M) decoder producing the control word and qualifiers.
module rv_decode
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    output logic [10:0] ctrl,
    output logic        sign,
    output logic        itype,
    output logic        rtype,
    output logic        mext,
    output logic        illegal,
    output logic        uses_rs1,
    output logic        uses_rs2
);
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [10:0] raw;
    logic        known;
    logic        m_enc;

    assign op    = instr[6:2];
    assign f3    = instr[14:12];
    assign itype = op == OP_ARITH_I;
    assign rtype = op == OP_ARITH_R;
    assign m_enc = rtype && instr[31:25] == FUNCT7_M;
    assign mext  = m_enc & ENABLE_M;

    always_comb begin
        raw   = '0;
        known = 1'b1;
        case (op)
            OP_LOAD:            raw = CTRL_LOAD;
            OP_STORE:           raw = CTRL_STORE;
            OP_BRANCH:          raw = CTRL_BRANCH;
            OP_JALR, OP_JAL:    raw = CTRL_JUMP;
            OP_ARITH_I:         raw = CTRL_ARITH_I;
            OP_ARITH_R:         raw = CTRL_ARITH_R;
            OP_AUIPC:           raw = CTRL_AUIPC;
            OP_LUI:             raw = CTRL_LUI;
            OP_SYSTEM, OP_FENCE: raw = '0;
            default:            known = 1'b0;
        endcase
    end

    // low bits other than 11 are compressed-format encodings, which this core cannot decode
    assign illegal  = !known || instr[1:0] != 2'b11 || (m_enc && !ENABLE_M);
    assign ctrl     = illegal ? '0 : raw;
    assign sign     = (op == OP_BRANCH && f3[2:1] == 2'b11) ||
                      (op == OP_LOAD && f3[2:1] == 2'b10) ||
                      (itype && f3 == 3'b011) ||
                      (rtype && f3 == 3'b011 && !instr[30] && !mext);
    assign uses_rs1 = !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_SYSTEM});
    assign uses_rs2 = op inside {OP_BRANCH, OP_STORE, OP_ARITH_R};
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered decode/control stage with load-use bubble, flush and divider stall.
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [10:0] out_ctrl,
    output logic        out_sign,
    output logic        out_itype,
    output logic        out_rtype,
    output logic        out_mext,
    output logic        out_illegal,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic        div_busy
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [10:0]   ctrl;
    logic          sign, itype, rtype, mext, illegal, uses_rs1, uses_rs2;
    logic          hazard, accept, handoff;
    div_state_t    state;
    logic [CW-1:0] cnt;

    rv_decode #(.ENABLE_M(ENABLE_M)) u_dec (
        .instr    (in_instr),
        .ctrl     (ctrl),
        .sign     (sign),
        .itype    (itype),
        .rtype    (rtype),
        .mext     (mext),
        .illegal  (illegal),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // a load still in the register cannot forward to a consumer entering behind it
    assign hazard   = in_valid & out_valid & out_ctrl[MEMREAD] & (out_rd != 5'd0) &
                      ((uses_rs1 & (in_instr[19:15] == out_rd)) | (uses_rs2 & (in_instr[24:20] == out_rd)));
    assign div_busy = state == DIV_WAIT;
    assign in_ready = !flush & !div_busy & !hazard & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign handoff  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_sign    <= 1'b0;
            out_itype   <= 1'b0;
            out_rtype   <= 1'b0;
            out_mext    <= 1'b0;
            out_illegal <= 1'b0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            state       <= RUN;
            cnt         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= RUN;
            cnt       <= '0;
        end else begin
            if (handoff && is_div(out_mext, out_funct3)) begin
                state <= DIV_WAIT;
                cnt   <= CW'(DIV_CYCLES);
            end else if (state == DIV_WAIT) begin
                cnt   <= cnt - 1'b1;
                state <= cnt == CW'(1) ? RUN : DIV_WAIT;
            end
            if (accept) begin
                out_valid   <= 1'b1;
                out_ctrl    <= ctrl;
                out_sign    <= sign;
                out_itype   <= itype;
                out_rtype   <= rtype;
                out_mext    <= mext;
                out_illegal <= illegal;
                out_rs1     <= in_instr[19:15];
                out_rs2     <= in_instr[24:20];
                out_rd      <= in_instr[11:7];
                out_funct3  <= in_instr[14:12];
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: vector table, corner sequences and randomized run against a cycle model.
module tb_decode_ctrl_stage;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic in_ready, out_valid, out_sign, out_itype, out_rtype, out_mext, out_illegal, div_busy;
    logic [10:0] out_ctrl;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic [2:0] out_funct3;

    logic z = 1'b0, one = 1'b1, v2 = 1'b0;
    logic [31:0] i2 = '0;
    logic r2, ov2, s2, it2, rt2, m2, il2, db2;
    logic [10:0] c2;
    logic [4:0] a2, b2, d2;
    logic [2:0] f2;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.ENABLE_M(1'b1), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out_ctrl(out_ctrl),
        .out_sign(out_sign), .out_itype(out_itype), .out_rtype(out_rtype), .out_mext(out_mext),
        .out_illegal(out_illegal), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .div_busy(div_busy)
    );

    decode_ctrl_stage #(.ENABLE_M(1'b0), .DIV_CYCLES(DC)) dut_nom (
        .clk(clk), .rst(rst), .flush(z), .in_valid(v2), .in_instr(i2),
        .in_ready(r2), .out_ready(one), .out_valid(ov2), .out_ctrl(c2),
        .out_sign(s2), .out_itype(it2), .out_rtype(rt2), .out_mext(m2),
        .out_illegal(il2), .out_rs1(a2), .out_rs2(b2), .out_rd(d2),
        .out_funct3(f2), .div_busy(db2)
    );

    typedef struct packed {
        logic [10:0] ctrl;
        logic sign, itype, rtype, mext, illegal;
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic u1, u2;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] ctrl;
        logic sign, itype, rtype, mext, illegal;
    } vec_t;

    bit   m_valid = 0, inited = 0;
    dec_t m_b = '0;
    int   m_busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected decode straight from the opcode table and qualifier rules (M enabled)
    function automatic dec_t ref_dec(input logic [31:0] i);
        dec_t d;
        logic [4:0] op;
        logic [2:0] f3;
        op = i[6:2];
        f3 = i[14:12];
        d = '0;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd = i[11:7];
        d.f3 = f3;
        d.itype = op == 5'b00100;
        d.rtype = op == 5'b01100;
        d.mext = d.rtype && i[31:25] == 7'd1;
        d.u1 = !(op inside {5'b01101, 5'b00101, 5'b11011, 5'b00011, 5'b11100});
        d.u2 = op inside {5'b11000, 5'b01000, 5'b01100};
        case (op)
            5'b00000: d.ctrl = 11'b00_0011_00_011;
            5'b01000: d.ctrl = 11'b00_0001_00_110;
            5'b11000: d.ctrl = 11'b00_0100_01_000;
            5'b11001, 5'b11011: d.ctrl = 11'b01_1000_00_011;
            5'b00100: d.ctrl = 11'b00_0000_10_011;
            5'b01100: d.ctrl = 11'b00_0000_10_001;
            5'b00101: d.ctrl = 11'b10_0000_00_011;
            5'b01101: d.ctrl = 11'b11_0000_11_011;
            5'b11100, 5'b00011: d.ctrl = '0;
            default: d.illegal = 1'b1;
        endcase
        if (i[1:0] != 2'b11) d.illegal = 1'b1;
        if (d.illegal) d.ctrl = '0;
        d.sign = (op == 5'b11000 && f3 >= 3'd6) || (op == 5'b00000 && (f3 == 3'd4 || f3 == 3'd5)) ||
                 (d.itype && f3 == 3'd3) || (d.rtype && f3 == 3'd3 && !i[30] && !d.mext);
        return d;
    endfunction

    task automatic step(input bit r, input bit fl, input bit iv, input logic [31:0] ins, input bit ordy, output bit rdy);
        dec_t nd;
        bit haz, erdy, ho;
        rst = r; flush = fl; in_valid = iv; in_instr = ins; out_ready = ordy;
        nd = ref_dec(ins);
        haz = iv && m_valid && m_b.ctrl[6] && m_b.rd != 0 &&
              ((nd.u1 && nd.rs1 == m_b.rd) || (nd.u2 && nd.rs2 == m_b.rd));
        erdy = !fl && m_busy == 0 && !haz && (!m_valid || ordy);
        @(negedge clk);
        rdy = in_ready;
        if (inited) begin
            chk("in_ready", in_ready, erdy);
            chk("div_busy", div_busy, m_busy != 0);
        end
        @(posedge clk);
        ho = m_valid && ordy;
        if (r) begin
            m_valid = 0; m_b = '0; m_busy = 0;
        end else if (fl) begin
            m_valid = 0; m_busy = 0;
        end else if (inited) begin
            if (ho && m_b.mext && m_b.f3[2]) m_busy = DC;
            else if (m_busy > 0) m_busy--;
            if (iv && erdy) begin
                m_b = nd; m_valid = 1;
            end else if (ho) m_valid = 0;
        end
        if (r) inited = 1;
        #1;
        if (inited) begin
            chk("out_valid", out_valid, m_valid);
            if (m_valid || r) begin
                chk("out_ctrl", out_ctrl, m_b.ctrl);
                chk("out_sign", out_sign, m_b.sign);
                chk("out_itype", out_itype, m_b.itype);
                chk("out_rtype", out_rtype, m_b.rtype);
                chk("out_mext", out_mext, m_b.mext);
                chk("out_illegal", out_illegal, m_b.illegal);
                chk("out_rs1", out_rs1, m_b.rs1);
                chk("out_rs2", out_rs2, m_b.rs2);
                chk("out_rd", out_rd, m_b.rd);
                chk("out_funct3", out_funct3, m_b.f3);
            end
        end
    endtask

    localparam logic [31:0] LW = 32'h0000A283, LW0 = 32'h0000A003, ADD = 32'h00728333, ADD0 = 32'h00700333;
    localparam logic [31:0] BLTU = 32'h0020E063, SW = 32'h0020A023, DIVU = 32'h0220D1B3, MULHU = 32'h0220B1B3;
    localparam logic [31:0] ADDI = 32'h00508193;

    initial begin
        vec_t vt[$];
        bit rdy;
        int stall, gaps;
        bit done;
        logic [4:0] ops[12] = '{5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011, 5'b00100,
                                5'b01100, 5'b00101, 5'b01101, 5'b11100, 5'b00011, 5'b11111};
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
        vt.push_back('{LW,           11'b00_0011_00_011, 0, 0, 0, 0, 0});
        vt.push_back('{32'h0000C283, 11'b00_0011_00_011, 1, 0, 0, 0, 0});
        vt.push_back('{32'h0000D283, 11'b00_0011_00_011, 1, 0, 0, 0, 0});
        vt.push_back('{32'h00009283, 11'b00_0011_00_011, 0, 0, 0, 0, 0});
        vt.push_back('{SW,           11'b00_0001_00_110, 0, 0, 0, 0, 0});
        vt.push_back('{BLTU,         11'b00_0100_01_000, 1, 0, 0, 0, 0});
        vt.push_back('{32'h0020D063, 11'b00_0100_01_000, 0, 0, 0, 0, 0});
        vt.push_back('{32'h000100E7, 11'b01_1000_00_011, 0, 0, 0, 0, 0});
        vt.push_back('{32'h000000EF, 11'b01_1000_00_011, 0, 0, 0, 0, 0});
        vt.push_back('{ADDI,         11'b00_0000_10_011, 0, 1, 0, 0, 0});
        vt.push_back('{32'h0050B193, 11'b00_0000_10_011, 1, 1, 0, 0, 0});
        vt.push_back('{ADD,          11'b00_0000_10_001, 0, 0, 1, 0, 0});
        vt.push_back('{32'h0020B1B3, 11'b00_0000_10_001, 1, 0, 1, 0, 0});
        vt.push_back('{32'h4020B1B3, 11'b00_0000_10_001, 0, 0, 1, 0, 0});
        vt.push_back('{MULHU,        11'b00_0000_10_001, 0, 0, 1, 1, 0});
        vt.push_back('{32'h00000097, 11'b10_0000_00_011, 0, 0, 0, 0, 0});
        vt.push_back('{32'h000000B7, 11'b11_0000_11_011, 0, 0, 0, 0, 0});
        vt.push_back('{32'h00000073, 11'b00_0000_00_000, 0, 0, 0, 0, 0});
        vt.push_back('{32'h0000000F, 11'b00_0000_00_000, 0, 0, 0, 0, 0});
        vt.push_back('{32'h0000007F, 11'b00_0000_00_000, 0, 0, 0, 0, 1});

        step(1, 0, 0, 0, 0, rdy);
        step(0, 0, 0, 0, 0, rdy);
        chk("idle_in_ready", rdy, 1);
        chk("idle_ctrl", out_ctrl, 0);

        foreach (vt[k]) begin
            step(0, 0, 1, vt[k].instr, 1, rdy);
            chk("vec_ctrl", out_ctrl, vt[k].ctrl);
            chk("vec_sign", out_sign, vt[k].sign);
            chk("vec_itype", out_itype, vt[k].itype);
            chk("vec_rtype", out_rtype, vt[k].rtype);
            chk("vec_mext", out_mext, vt[k].mext);
            chk("vec_illegal", out_illegal, vt[k].illegal);
            step(0, 0, 0, 0, 1, rdy);
        end

        // M ops rejected when the extension is disabled
        v2 = 1; i2 = DIVU;
        step(0, 0, 0, 0, 1, rdy);
        chk("nom_illegal", il2, 1);
        chk("nom_ctrl", c2, 0);
        chk("nom_mext", m2, 0);
        i2 = ADD;
        step(0, 0, 0, 0, 1, rdy);
        chk("nom_add_illegal", il2, 0);
        chk("nom_add_ctrl", c2, 11'b00_0000_10_001);
        v2 = 0;

        foreach (ops[k]) begin
            step(0, 0, 1, {f7s[k % 3], 5'd1, 5'd2, 3'(k), 5'd3, ops[k], 2'b11}, 1, rdy);
            step(0, 0, 0, 0, 1, rdy);
        end

        step(0, 0, 1, LW, 1, rdy);
        chk("lw_rd", out_rd, 5);
        stall = 0; gaps = 0; done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            step(0, 0, 1, ADD, 1, rdy);
            if (!rdy) stall++;
            if (!out_valid) gaps++;
            done = rdy;
        end
        chk("luse_accepted", done, 1);
        chk("luse_stalls", stall, 1);
        chk("luse_bubbles", gaps, 1);
        chk("luse_add_ctrl", out_ctrl, 11'b00_0000_10_001);
        chk("luse_add_rtype", out_rtype, 1);
        step(0, 0, 0, 0, 1, rdy);

        step(0, 0, 1, LW0, 1, rdy);
        step(0, 0, 1, ADD0, 1, rdy);
        chk("lw0_no_stall", rdy, 1);
        chk("lw0_no_bubble", out_valid, 1);
        step(0, 0, 0, 0, 1, rdy);

        step(0, 0, 1, BLTU, 1, rdy);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, SW, 0, rdy);
            chk("bp_in_ready", rdy, 0);
            chk("bp_ctrl_hold", out_ctrl, 11'b00_0100_01_000);
            chk("bp_sign_hold", out_sign, 1);
        end
        step(0, 0, 1, SW, 1, rdy);
        chk("bp_release_ready", rdy, 1);
        chk("bp_release_ctrl", out_ctrl, 11'b00_0001_00_110);
        step(0, 0, 0, 0, 1, rdy);

        step(0, 0, 1, DIVU, 1, rdy);
        step(0, 0, 0, 0, 1, rdy);
        chk("div_busy_start", div_busy, 1);
        stall = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(0, 0, 1, ADDI, 1, rdy);
            if (!rdy) stall++;
            done = rdy;
        end
        chk("div_released", done, 1);
        chk("div_stall_cycles", stall, DC);
        step(0, 0, 0, 0, 1, rdy);

        step(0, 0, 1, MULHU, 1, rdy);
        chk("mulhu_mext", out_mext, 1);
        chk("mulhu_sign", out_sign, 0);
        step(0, 0, 0, 0, 1, rdy);
        chk("mul_no_busy", div_busy, 0);
        step(0, 0, 1, ADDI, 1, rdy);
        chk("mul_no_stall", rdy, 1);
        step(0, 0, 0, 0, 1, rdy);

        step(0, 0, 1, DIVU, 1, rdy);
        step(0, 0, 0, 0, 1, rdy);
        step(0, 0, 0, 0, 1, rdy);
        chk("flush_pre_busy", div_busy, 1);
        step(0, 1, 0, 0, 1, rdy);
        chk("flush_clears_busy", div_busy, 0);
        step(0, 0, 1, ADDI, 0, rdy);
        step(0, 1, 1, SW, 0, rdy);
        chk("flush_in_ready", rdy, 0);
        chk("flush_drop_valid", out_valid, 0);

        step(0, 0, 1, LW, 0, rdy);
        step(1, 0, 1, ADDI, 0, rdy);
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_busy", div_busy, 0);

        for (int k = 0; k < 600; k++) begin
            logic [31:0] ins;
            ins = {f7s[$urandom_range(0, 2)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 11)], 2'b11};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
                 ins, $urandom_range(0, 9) < 7, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
